// File: rtl/vga_frame_scheduler.sv
// Shares the single VGA write port between painter clients.
// Each game tick runs an erase pass, a game_update pulse, then a draw pass.
module vga_frame_scheduler #(
    parameter int         NUM_CLIENTS  = 3,
    parameter int         TIMEOUT      = 20000,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     game_pulse,
    output logic [NUM_CLIENTS-1:0]   client_start,
    input  logic [NUM_CLIENTS-1:0]   client_done,
    input  logic [NUM_CLIENTS-1:0]   client_plot,
    input  logic [8*NUM_CLIENTS-1:0] client_x,
    input  logic [7*NUM_CLIENTS-1:0] client_y,
    input  logic [3*NUM_CLIENTS-1:0] client_colour,
    output logic                     erase,
    output logic                     plot,
    output logic [7:0]               x,
    output logic [6:0]               y,
    output logic [2:0]               colour,
    output logic                     game_update,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err
);
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, E_START, E_WAIT, UPDATE, D_START, D_WAIT, DONE
    } state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          nidx;
    logic [CW-1:0]          cnt;
    logic                   pending;
    logic                   in_wait;
    logic                   done_now;
    logic                   tmo_now;
    logic                   last;
    logic [NUM_CLIENTS-1:0] one;

    logic [7:0] cx [NUM_CLIENTS];
    logic [6:0] cy [NUM_CLIENTS];
    logic [2:0] cc [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign cx[i] = client_x[8*i +: 8];
        assign cy[i] = client_y[7*i +: 7];
        assign cc[i] = client_colour[3*i +: 3];
    end

    assign one      = NUM_CLIENTS'(1);
    assign nidx     = idx + IW'(1);
    assign in_wait  = (state == E_WAIT) || (state == D_WAIT);
    assign done_now = client_done[idx];
    assign tmo_now  = (cnt == CW'(TIMEOUT - 1));
    assign last     = (idx == IW'(NUM_CLIENTS - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            pending      <= 1'b0;
            client_start <= '0;
            erase        <= 1'b0;
            plot         <= 1'b0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            game_update  <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            client_start <= '0;
            game_update  <= 1'b0;
            frame_done   <= 1'b0;
            plot         <= 1'b0;

            if (in_wait && client_plot[idx]) begin
                plot   <= 1'b1;
                x      <= cx[idx];
                y      <= cy[idx];
                colour <= (state == E_WAIT) ? ERASE_COLOUR : cc[idx];
            end

            // One tick may queue behind the running frame; more are dropped.
            if (game_pulse && state != IDLE) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (game_pulse || pending) begin
                        state        <= E_START;
                        pending      <= pending & game_pulse;
                        client_start <= one << idx;
                        erase        <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                E_START, D_START: begin
                    cnt   <= '0;
                    state <= (state == E_START) ? E_WAIT : D_WAIT;
                end
                E_WAIT, D_WAIT: begin
                    if (done_now || tmo_now) begin
                        if (!done_now) timeout_err <= 1'b1;
                        if (!last) begin
                            idx          <= nidx;
                            client_start <= one << nidx;
                            state <= (state == E_WAIT) ? E_START : D_START;
                        end else begin
                            idx <= '0;
                            if (state == E_WAIT) begin
                                state       <= UPDATE;
                                erase       <= 1'b0;
                                game_update <= 1'b1;
                            end else begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                UPDATE: begin
                    state        <= D_START;
                    client_start <= one;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Randomized bench: frames are planned as a cycle timeline from slot lengths,
// and every DUT output is compared each cycle against that timeline.
module tb_vga_frame_scheduler;
    localparam int NC = 3;
    localparam int T  = 16;
    localparam int N  = 8192;

    logic            CLOCK_50 = 1'b0;
    logic            resetn = 1'b0;
    logic            game_pulse = 1'b0;
    logic [NC-1:0]   client_done = '0;
    logic [NC-1:0]   client_plot = '0;
    logic [8*NC-1:0] client_x = '0;
    logic [7*NC-1:0] client_y = '0;
    logic [3*NC-1:0] client_colour = '0;
    logic [NC-1:0]   client_start;
    logic            erase, plot, game_update, frame_done;
    logic            busy, overrun, timeout_err;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;

    vga_frame_scheduler #(.NUM_CLIENTS(NC), .TIMEOUT(T),
                          .ERASE_COLOUR(3'b000)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .game_pulse(game_pulse),
        .client_start(client_start), .client_done(client_done),
        .client_plot(client_plot), .client_x(client_x),
        .client_y(client_y), .client_colour(client_colour),
        .erase(erase), .plot(plot), .x(x), .y(y), .colour(colour),
        .game_update(game_update), .frame_done(frame_done),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Expected timeline, indexed by cycle number.
    int          e_start [N];
    int          e_grant [N];
    bit          e_erase [N];
    bit          e_upd   [N];
    bit          e_fdone [N];
    bit          e_busy  [N];
    bit          e_tmo   [N];
    bit [NC-1:0] e_dd    [N];

    int       cyc_n = 0;
    int       fd = -2;
    bit       pend = 0;
    bit       exp_plot = 0, exp_ovr = 0, exp_tmo = 0;
    bit [7:0] exp_x = 0;
    bit [6:0] exp_y = 0;
    bit [2:0] exp_col = 0;
    int       tests = 0, fails = 0;
    int       dmode = 0;
    bit [2:0] slow_mask = 0;
    bit       noise = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %0h expected %0h",
                   tag, cyc_n, obs, exp);
        end
    endtask

    function automatic int pick_delay(input int i);
        int r;
        if (slow_mask[i]) return T + 4;
        if (dmode == 0) return 5;
        r = $urandom_range(0, 9);
        if (r == 0) return T + 4;
        if (r == 1) return T;
        return $urandom_range(1, 6);
    endfunction

    task automatic clear_from(input int c);
        for (int k = c; k < N && k < c + 400; k++) begin
            e_start[k] = -1; e_grant[k] = -1; e_erase[k] = 0;
            e_upd[k] = 0; e_fdone[k] = 0; e_busy[k] = 0;
            e_tmo[k] = 0; e_dd[k] = '0;
        end
    endtask

    // A slot is one start cycle plus min(delay, T) wait cycles.
    task automatic plan(input int f);
        int s, d, w;
        s = f;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NC; i++) begin
                d = pick_delay(i);
                w = (d > T) ? T : d;
                e_start[s] = i;
                for (int k = 0; k <= w; k++) e_erase[s+k] = (p == 0);
                for (int k = 1; k <= w; k++) e_grant[s+k] = i;
                if (d <= T) e_dd[s+d][i] = 1'b1;
                else        e_tmo[s+T+1] = 1'b1;
                s += 1 + w;
            end
            if (p == 0) begin
                e_upd[s] = 1'b1;
                s++;
            end
        end
        e_fdone[s] = 1'b1;
        for (int k = f; k <= s; k++) e_busy[k] = 1'b1;
        fd = s;
    endtask

    task automatic step(input bit gp, input bit rn);
        int c, g;
        bit [NC-1:0] es;
        @(negedge CLOCK_50);
        c = cyc_n;
        es = '0;
        if (e_start[c] >= 0) es[e_start[c]] = 1'b1;
        chk("client_start", 32'(client_start), 32'(es));
        chk("erase", 32'(erase), 32'(e_erase[c]));
        chk("game_update", 32'(game_update), 32'(e_upd[c]));
        chk("frame_done", 32'(frame_done), 32'(e_fdone[c]));
        chk("busy", 32'(busy), 32'(e_busy[c]));
        chk("plot", 32'(plot), 32'(exp_plot));
        chk("x", 32'(x), 32'(exp_x));
        chk("y", 32'(y), 32'(exp_y));
        chk("colour", 32'(colour), 32'(exp_col));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("timeout_err", 32'(timeout_err), 32'(exp_tmo));

        resetn = rn;
        game_pulse = gp;
        for (int i = 0; i < NC; i++) begin
            client_plot[i] = 1'($urandom_range(0, 1));
            client_x[8*i +: 8] = 8'($urandom);
            client_y[7*i +: 7] = 7'($urandom);
            client_colour[3*i +: 3] = 3'($urandom);
        end
        client_done = e_dd[c];
        if (noise)
            for (int i = 0; i < NC; i++)
                if (e_grant[c] != i && $urandom_range(0, 3) == 0)
                    client_done[i] = 1'b1;

        if (!rn) begin
            clear_from(c + 1);
            pend = 0; exp_ovr = 0; exp_tmo = 0;
            exp_plot = 0; exp_x = 0; exp_y = 0; exp_col = 0;
            fd = c;
        end else begin
            g = e_grant[c];
            exp_plot = (g >= 0) ? client_plot[g] : 1'b0;
            if (exp_plot) begin
                exp_x = client_x[8*g +: 8];
                exp_y = client_y[7*g +: 7];
                exp_col = e_erase[c] ? 3'b000 : client_colour[3*g +: 3];
            end
            if (e_tmo[c+1]) exp_tmo = 1;
            if (c > fd) begin
                if (pend || gp) begin
                    pend = pend && gp;
                    plan(c + 1);
                end
            end else if (gp) begin
                if (pend) exp_ovr = 1;
                else      pend = 1;
            end
        end
        cyc_n++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(cyc_n > fd + 1 && !pend) && n < 600) begin
            step(0, 1);
            n++;
        end
        chk("idle_bound", 32'(n < 600), 32'd1);
        repeat (3) step(0, 1);
    endtask

    initial begin
        int n;
        clear_from(0);
        repeat (3) step(0, 0);

        step(1, 1);
        wait_idle();

        noise = 1;
        step(1, 1);
        wait_idle();

        slow_mask = 3'b100;
        step(1, 1);
        wait_idle();
        slow_mask = 3'b000;

        step(1, 1);
        repeat (10) step(0, 1);
        step(1, 1);
        repeat (5) step(0, 1);
        step(1, 1);
        wait_idle();

        step(0, 0);
        slow_mask = 3'b100;
        step(1, 1);
        step(0, 1);
        step(1, 1);
        step(1, 1);
        slow_mask = 3'b000;
        n = 0;
        while (!(e_grant[cyc_n] == 1 && !e_erase[cyc_n]) && n < 500) begin
            step(0, 1);
            n++;
        end
        chk("dwait_bound", 32'(n < 500), 32'd1);
        step(0, 0);
        repeat (3) step(0, 1);
        step(1, 1);
        wait_idle();

        dmode = 1;
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(1, 40))
                step($urandom_range(0, 15) == 0, $urandom_range(0, 199) != 0);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_frame_scheduler.md
Name: vga_frame_scheduler

Overview:
- Sequences and shares the single VGA adapter write port (x/y/colour/plot) between NUM_CLIENTS pixel painters, e.g. bird box, pipe one and pipe two.
- On each game tick it runs an erase pass: every client redraws its old position in black.
- It then pulses game_update so game logic advances positions, and runs a draw pass: every client draws its new position.
- It sits between the game-tick generator, the painter blocks and vga_adapter.

Parameters:
NUM_CLIENTS, 3, number of painter clients; served in index order 0..NUM_CLIENTS-1.
TIMEOUT, 20000, max cycles a granted client may take before being skipped.
ERASE_COLOUR, 3'b000, colour forced onto the VGA port during the erase pass.

Ports:
CLOCK_50  input  1  system clock; all logic on posedge.
resetn  input  1  synchronous, active-low reset.
game_pulse  input  1  one-cycle game-tick request.
client_start  output  NUM_CLIENTS  one-cycle start pulse to the granted client.
client_done  input  NUM_CLIENTS  one-cycle pulse; client finished its pass.
client_plot  input  NUM_CLIENTS  per-client pixel write strobe.
client_x  input  8*NUM_CLIENTS  packed x; client i in bits [8i+7:8i].
client_y  input  7*NUM_CLIENTS  packed y; client i in bits [7i+6:7i].
client_colour  input  3*NUM_CLIENTS  packed colour; client i in bits [3i+2:3i].
erase  output  1  high for the whole erase pass; clients paint their old position.
plot  output  1  registered write strobe to vga_adapter.
x  output  8  registered pixel x.
y  output  7  registered pixel y.
colour  output  3  registered pixel colour.
game_update  output  1  one-cycle pulse between the two passes.
frame_done  output  1  one-cycle pulse when the draw pass completes.
busy  output  1  high in every state except IDLE.
overrun  output  1  sticky: a tick was dropped.
timeout_err  output  1  sticky: a client was skipped.

Behaviour:
- Reset (resetn=0 at a clock edge): all outputs 0, state IDLE, client index 0, pending flag 0, timeout counter 0. Reset mid-pass abandons the pass immediately; no further start or plot is issued.
- States:
  - IDLE: go to E_START on game_pulse or pending.
  - E_START: client_start[idx]=1 for one cycle; then E_WAIT.
  - E_WAIT: wait for client_done[idx] or timeout. If idx < NUM_CLIENTS-1: idx+1, go to E_START. Else: idx=0, go to UPDATE.
  - UPDATE: game_update=1 for one cycle; then D_START.
  - D_START / D_WAIT: same as the erase states, with erase=0. The last client goes to DONE.
  - DONE: frame_done=1 for one cycle; then IDLE.
- erase=1 in E_START and E_WAIT only.
- client_done is sampled only in the *_WAIT states. A done bit from a non-granted client is ignored, as is one arriving during *_START.
- VGA mux, one cycle latency. Each cycle:
  - plot <= client_plot[idx] in *_WAIT, else 0.
  - x, y <= slices of the granted client.
  - colour <= ERASE_COLOUR during the erase pass, else the client's colour.
  - Writes from non-granted clients are never forwarded.
  - x, y and colour hold their last value when plot=0.
- Timeout:
  - The counter clears in *_START and increments in *_WAIT.
  - When it reaches TIMEOUT-1 without done, the scheduler sets timeout_err and advances exactly as if done arrived.
  - Counter width is clog2(TIMEOUT+1); it never wraps.
- Tick queueing while busy:
  - The first game_pulse sets pending.
  - A game_pulse while pending is already 1 is dropped and sets overrun.
  - pending clears on the IDLE->E_START transition.
  - A game_pulse arriving in the DONE cycle sets pending, so the next frame starts after one IDLE cycle.
- game_pulse and done in the same cycle: the scheduler advances and also latches pending.
- The sticky flags clear only on reset.

Test Plan:
- Three clients, each doing done 5 cycles after start, one game_pulse:
  - client_start bits pulse in the order 1,2,4 with erase=1, then game_update, then 1,2,4 with erase=0, then frame_done.
  - busy high for the whole frame; frame_done exactly 1 cycle before busy falls.
- Client 1 plots (x=8'd40, y=7'd17, colour=3'b010) during the erase pass -> next cycle plot=1, x=40, y=17, colour=000.
  - The same plot during the draw pass -> colour=010.
  - Client 0 asserting plot while client 1 is granted -> plot stays 0.
- Client 2 never asserts done (TIMEOUT=16) -> after 16 cycles in E_WAIT timeout_err=1 and the scheduler moves to UPDATE.
  - In the draw pass client 2 again times out; frame_done still pulses.
- Two game_pulses mid-frame -> pending set, overrun=1; exactly one additional frame runs after DONE.
- resetn=0 for one cycle during D_WAIT of client 1:
  - the next cycle all outputs are 0 and the state is IDLE;
  - overrun and timeout_err are cleared;
  - a later game_pulse restarts from the client 0 erase pass.
- Stray client_done[0] in IDLE and during client 1's E_START -> ignored; the sequence is unchanged.
